adder_result_collector: RTL
===========================

Name: adder_result_collector

Overview:
- Downstream stage of the 8-bit adder. Captures each {carry, sum} result in a small FIFO and presents it to the consumer with a valid/ready handshake.
- Keeps a saturating running total of all accepted results and a wrapping count of them, for checking and statistics.
- Sits between the adder's sum/carry outputs and the next consumer; the producer qualifies each result with in_valid.

Parameters:
- DATA_W, 8, width of the adder sum (carry adds 1 bit).
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- ACC_W, 16, accumulator width; must be at least DATA_W+1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer has a result on in_sum/in_carry.
- in_ready  out  1  collector can accept a result this cycle.
- in_sum  in  DATA_W  adder sum.
- in_carry  in  1  adder carry-out.
- out_valid  out  1  out_data holds the FIFO head.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  DATA_W+1  {carry, sum} of the head entry.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- acc_clr  in  1  synchronous clear of acc_value, acc_sat and result_cnt.
- acc_value  out  ACC_W  saturating sum of accepted results.
- acc_sat  out  1  sticky flag: the accumulator has saturated.
- result_cnt  out  8  count of accepted results, wraps modulo 256.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - in_ready=0, out_valid=0, out_data=0, level=0, acc_value=0, acc_sat=0, result_cnt=0.
  - FIFO pointers cleared.
  - in_ready rises on the first clk edge after rst deasserts.
- Accept (push): in_valid && in_ready at a rising edge. {in_carry, in_sum} is written at the tail.
- Pop: out_valid && out_ready at a rising edge. The head advances.
- in_ready and out_valid are registered, computed from next-state occupancy:
  - in_ready = (level_next < DEPTH)
  - out_valid = (level_next > 0)
- out_data is the head storage entry, driven from registers. It is 0 when the FIFO is empty.
- Latency: a result accepted at edge N appears on out_data/out_valid after edge N. There is no combinational path from in_* to out_*.
- Full (level=DEPTH):
  - in_ready=0, so no push occurs.
  - A pop in the full cycle raises in_ready after that edge.
- Empty (level=0):
  - out_valid=0; out_ready is ignored.
  - A push raises out_valid after the edge.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- in_valid without in_ready is not an error. The producer holds its data; nothing is stored.
- Accumulator, updated on accept only:
  - acc_next = acc_value + zero-extended {in_carry, in_sum}.
  - If the true sum is 2^ACC_W or more: acc_value = 2^ACC_W-1 and acc_sat=1.
  - acc_sat stays 1 until acc_clr or rst.
- result_cnt increments by 1 per accept and wraps 255 -> 0 with no flag.
- acc_clr:
  - Alone: acc_value=0, acc_sat=0, result_cnt=0 after the edge.
  - Same cycle as an accept: the clear applies first, then the accept. Result: acc_value = incoming value, result_cnt=1, acc_sat=0.
  - acc_clr does not affect the FIFO.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and FIFO contents are discarded. The producer must re-present any in-flight result after in_ready rises.

Test Plan:
- Reset release: hold rst 3 cycles, then deassert -> all outputs 0 during reset; in_ready=1 one edge after release; out_valid=0.
- Single transfer: sum=0xFF, carry=1 accepted with out_ready=0 -> next cycle out_valid=1, out_data=0x1FF, level=1, acc_value=0x01FF, result_cnt=1. Then out_ready=1 -> out_valid=0, level=0.
- Backpressure: push 5 results 0x001..0x005 with out_ready=0 -> in_ready=0 after 4th accept, level=4, 5th held. Then pop one -> in_ready=1, 5th accepted, pops in order 0x001..0x005.
- Concurrent push/pop at level=2, in_valid=out_ready=1 for 6 cycles -> level stays 2, output order preserved across pointer wrap.
- Saturation: accept 0x1FF repeatedly (ACC_W=16) -> at accept 129, true sum 65919 > 65535, so acc_value=0xFFFF and acc_sat=1. Further accepts keep 0xFFFF. acc_clr together with an accept of 0x003 -> acc_value=0x0003, acc_sat=0, result_cnt=1.
- Reset mid-stream: level=3, assert rst asynchronously between edges -> level=0, out_valid=0, in_ready=0 immediately; after release the FIFO is empty and acc_value=0.

Source files
------------

// File: rtl/adder_result_collector_if.sv
// Handshake and statistics bundle between the adder, the result collector and its consumer.
// The master modport is the producer/consumer side; the collector takes the slave modport.
interface adder_result_collector_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ACC_W  = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_carry;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W:0]   out_data;
  logic [LVL_W-1:0]  level;
  logic              acc_clr;
  logic [ACC_W-1:0]  acc_value;
  logic              acc_sat;
  logic [7:0]        result_cnt;

  modport master (
    output in_valid, in_sum, in_carry, out_ready, acc_clr,
    input  in_ready, out_valid, out_data, level, acc_value, acc_sat, result_cnt
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready, acc_clr,
    output in_ready, out_valid, out_data, level, acc_value, acc_sat, result_cnt
  );
endinterface

// File: rtl/adder_result_collector.sv
// Buffers adder {carry, sum} results in a small FIFO with valid/ready on both sides and keeps
// a saturating running total plus a wrapping count of every accepted result.
module adder_result_collector #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ACC_W  = 16
) (
  input logic                     clk,
  input logic                     rst,
  adder_result_collector_if.slave io_bus
);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = DATA_W + 1;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat;
  logic [7:0]       r_cnt;

  logic             w_push;
  logic             w_pop;
  logic [ENT_W-1:0] w_in_data;
  logic [LVL_W-1:0] w_level_next;
  logic [ACC_W-1:0] w_acc_base;
  logic             w_sat_base;
  logic [7:0]       w_cnt_base;
  logic [ACC_W:0]   w_acc_sum;

  assign w_push    = io_bus.in_valid && r_in_ready;
  assign w_pop     = r_out_valid && io_bus.out_ready;
  assign w_in_data = {io_bus.in_carry, io_bus.in_sum};

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop) begin
      w_level_next = r_level + LVL_W'(1);
    end else if (!w_push && w_pop) begin
      w_level_next = r_level - LVL_W'(1);
    end
  end

  // A clear in the same cycle as an accept zeroes the base before the new result is added.
  assign w_acc_base = io_bus.acc_clr ? '0 : r_acc;
  assign w_sat_base = io_bus.acc_clr ? 1'b0 : r_sat;
  assign w_cnt_base = io_bus.acc_clr ? 8'd0 : r_cnt;
  assign w_acc_sum  = {1'b0, w_acc_base} + (ACC_W + 1)'(w_in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level     <= w_level_next;
      r_in_ready  <= (w_level_next < LVL_W'(DEPTH));
      r_out_valid <= (w_level_next != '0);
    end
  end

  // Storage needs no reset: stale entries are never visible because out_data is gated by valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      r_cnt <= 8'd0;
    end else if (w_push) begin
      r_acc <= w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
      r_sat <= w_sat_base | w_acc_sum[ACC_W];
      r_cnt <= w_cnt_base + 8'd1;
    end else if (io_bus.acc_clr) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      r_cnt <= 8'd0;
    end
  end

  assign io_bus.in_ready   = r_in_ready;
  assign io_bus.out_valid  = r_out_valid;
  assign io_bus.out_data   = r_out_valid ? r_mem[r_rd_ptr] : '0;
  assign io_bus.level      = r_level;
  assign io_bus.acc_value  = r_acc;
  assign io_bus.acc_sat    = r_sat;
  assign io_bus.result_cnt = r_cnt;
endmodule
